// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared bus encodings, I/O map and timer register layout
// Purpose: constants shared by the CPU-side I/O responders.
// Ports: none (package).
package mmio_pkg;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'b00,
    CMD_MWRITE = 2'b01,
    CMD_MREAD  = 2'b10
  } mem_cmd_e;

  // I/O half of the address space (mem_addr[8] = 1)
  localparam logic [8:0] LED_ADDR   = 9'h100;
  localparam logic [8:0] SW_ADDR    = 9'h140;
  localparam logic [8:0] TIMER_ADDR = 9'h180;

  // Timer register indices (mem_addr[2:0])
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_ONESHOT = 2;

  // STATUS bit positions
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

endpackage

// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - CPU memory bus as seen by an I/O responder
// Purpose: bundles the CPU bus signals for one responder.
// Ports (modport slave): in mem_cmd[1:0], mem_addr[8:0], write_data[15:0];
//                        out read_data[15:0], rd_sel.
interface mmio_timer_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_sel;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, rd_sel
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, rd_sel
  );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - programmable tick divider for the timer
// Purpose: emits one tick every prescale+1 enabled cycles.
// Ports: clk, reset_n (async, active-low), en, clr, prescale[15:0] -> tick.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] pcnt;

  // Tick is decoded from the registered count so the counter update lands
  // on the edge that ends the tick cycle.
  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= 16'h0000;
    end else if (!en || clr || tick) begin
      pcnt <= 16'h0000;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped 16-bit timer/compare peripheral
// Purpose: prescaled up-counter with compare match, auto-reload, one-shot,
//          W1C status flags and a level interrupt.
// Ports: clk, reset_n (async, active-low), bus (mmio_timer_if.slave),
//        irq (= STATUS.MATCH).
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [8:0] BASE_ADDR = TIMER_ADDR
) (
  input  logic         clk,
  input  logic         reset_n,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  logic        hit;
  logic [2:0]  idx;
  logic        wr_en;
  logic        wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;

  logic        en_q, auto_q, oneshot_q;
  logic [15:0] count_q, compare_q, prescale_q;
  logic        match_q, ovf_q;

  logic        tick;
  logic [15:0] count_nxt;
  logic        match_set, ovf_set, oneshot_stop;
  logic [15:0] tmr_rdata;

  // ---------------------------------------------------------------- decode
  assign hit         = (bus.mem_addr[8:3] == BASE_ADDR[8:3]);
  assign idx         = bus.mem_addr[2:0];
  assign wr_en       = hit && (bus.mem_cmd == CMD_MWRITE);
  assign wr_ctrl     = wr_en && (idx == REG_CTRL);
  assign wr_count    = wr_en && (idx == REG_COUNT);
  assign wr_compare  = wr_en && (idx == REG_COMPARE);
  assign wr_status   = wr_en && (idx == REG_STATUS);
  assign wr_prescale = wr_en && (idx == REG_PRESCALE);

  // ------------------------------------------------------------- prescaler
  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en_q),
    .clr      (wr_ctrl || wr_prescale),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // --------------------------------------------------------- counter logic
  // A CPU write to COUNT overrides the tick update and suppresses any flag
  // the tick would otherwise have raised.
  always_comb begin
    count_nxt    = count_q;
    match_set    = 1'b0;
    ovf_set      = 1'b0;
    oneshot_stop = 1'b0;
    if (wr_count) begin
      count_nxt = bus.write_data;
    end else if (tick) begin
      if (count_q == compare_q) begin
        match_set    = 1'b1;
        count_nxt    = auto_q ? 16'h0000 : count_q + 16'd1;
        oneshot_stop = oneshot_q;
      end else if (count_q == 16'hFFFF) begin
        count_nxt = 16'h0000;
        ovf_set   = 1'b1;
      end else begin
        count_nxt = count_q + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      oneshot_q  <= 1'b0;
      count_q    <= 16'h0000;
      compare_q  <= 16'h0000;
      prescale_q <= 16'h0000;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // CPU write to CTRL wins over the one-shot self-disable.
      if (wr_ctrl) begin
        en_q      <= bus.write_data[CTRL_EN];
        auto_q    <= bus.write_data[CTRL_AUTO];
        oneshot_q <= bus.write_data[CTRL_ONESHOT];
      end else if (oneshot_stop) begin
        en_q <= 1'b0;
      end

      count_q <= count_nxt;

      if (wr_compare) begin
        compare_q <= bus.write_data;
      end
      if (wr_prescale) begin
        prescale_q <= bus.write_data;
      end

      // Hardware set beats a same-cycle W1C.
      match_q <= match_set || (match_q && !(wr_status && bus.write_data[STAT_MATCH]));
      ovf_q   <= ovf_set   || (ovf_q   && !(wr_status && bus.write_data[STAT_OVF]));
    end
  end

  // ----------------------------------------------------------- read path
  always_comb begin
    tmr_rdata = 16'h0000;
    case (idx)
      REG_CTRL:     tmr_rdata = {13'h0000, oneshot_q, auto_q, en_q};
      REG_COUNT:    tmr_rdata = count_q;
      REG_COMPARE:  tmr_rdata = compare_q;
      REG_STATUS:   tmr_rdata = {14'h0000, ovf_q, match_q};
      REG_PRESCALE: tmr_rdata = prescale_q;
      default:      tmr_rdata = 16'h0000;
    endcase
  end

  assign bus.rd_sel    = hit && (bus.mem_cmd == CMD_MREAD);
  assign bus.read_data = bus.rd_sel ? tmr_rdata : 16'h0000;
  assign irq           = match_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - scoreboard testbench for mmio_timer
module tb_mmio_timer;
  import mmio_pkg::*;

  localparam logic [8:0] BASE = 9'h180;

  logic clk = 1'b0;
  logic reset_n;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exp_sel;
    logic [15:0] exp_data;
    logic        exp_irq;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_id   = 0;

  // ------------------------------------------------ reference model state
  // Plain integers holding the architectural register file, advanced once
  // per clock edge from the rules of the timer.
  bit m_rst;
  int m_en, m_auto, m_oneshot;
  int m_count, m_compare, m_prescale, m_pcnt;
  int m_match, m_ovf;

  function automatic void model_reset();
    m_en = 0; m_auto = 0; m_oneshot = 0;
    m_count = 0; m_compare = 0; m_prescale = 0; m_pcnt = 0;
    m_match = 0; m_ovf = 0;
  endfunction

  function automatic bit is_hit(logic [8:0] a);
    return a[8:3] == BASE[8:3];
  endfunction

  function automatic logic [15:0] model_read(logic [2:0] i);
    case (i)
      3'd0: return 16'(m_en + 2 * m_auto + 4 * m_oneshot);
      3'd1: return 16'(m_count);
      3'd2: return 16'(m_compare);
      3'd3: return 16'(m_match + 2 * m_ovf);
      3'd4: return 16'(m_prescale);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void model_step(logic [1:0] cmd, logic [8:0] a, logic [15:0] wd);
    bit wr;
    int i, d;
    bit tick;
    int nc, nen;
    bit setm, seto;
    if (m_rst) begin
      model_reset();
      return;
    end
    wr   = is_hit(a) && (cmd == CMD_MWRITE);
    i    = int'(a[2:0]);
    d    = int'(wd);
    tick = (m_en == 1) && (m_pcnt == m_prescale);
    nc = m_count; nen = m_en; setm = 0; seto = 0;
    if (wr && i == 1) nc = d;
    else if (tick) begin
      if (m_count == m_compare) begin
        setm = 1;
        nc = (m_auto == 1) ? 0 : (m_count + 1) % 65536;
        if (m_oneshot == 1) nen = 0;
      end else begin
        nc = (m_count + 1) % 65536;
        if (nc == 0) seto = 1;
      end
    end
    if (!m_en || (wr && (i == 0 || i == 4)) || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    if (wr && i == 0) begin
      m_en = d % 2; m_auto = (d / 2) % 2; m_oneshot = (d / 4) % 2;
    end else m_en = nen;
    m_count = nc;
    if (wr && i == 2) m_compare = d;
    if (wr && i == 4) m_prescale = d;
    if (setm) m_match = 1;
    else if (wr && i == 3 && wd[0]) m_match = 0;
    if (seto) m_ovf = 1;
    else if (wr && i == 3 && wd[1]) m_ovf = 0;
  endfunction

  // ------------------------------------------------------------- helpers
  task automatic check(bit ok, string name, int act, int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Drives one bus cycle (called at posedge+1), queues the expected
  // response, then advances the model on the closing edge.
  task automatic issue(logic [1:0] cmd, logic [8:0] a, logic [15:0] wd,
                       bit use_const, logic [15:0] cdata, logic cirq);
    exp_t e;
    bus.mem_cmd    = cmd;
    bus.mem_addr   = a;
    bus.write_data = wd;
    e.exp_sel  = is_hit(a) && (cmd == CMD_MREAD);
    e.exp_data = e.exp_sel ? (use_const ? cdata : model_read(a[2:0])) : 16'h0000;
    e.exp_irq  = use_const ? cirq : logic'(m_match[0]);
    e.id       = cyc_id++;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(cmd, a, wd);
    #1;
  endtask

  task automatic wr(logic [2:0] i, logic [15:0] wd);
    issue(CMD_MWRITE, {BASE[8:3], i}, wd, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic rd_chk(logic [2:0] i, logic [15:0] d, logic q);
    issue(CMD_MREAD, {BASE[8:3], i}, 16'h0, 1'b1, d, q);
  endtask

  task automatic idle();
    issue(CMD_NONE, BASE, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic stop_and_clear();
    wr(3'd0, 16'h0000);
    wr(3'd3, 16'h0003);
  endtask

  // ---------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(bus.rd_sel == e.exp_sel, $sformatf("rd_sel[%0d]", e.id), bus.rd_sel, e.exp_sel);
      check(bus.read_data == e.exp_data, $sformatf("read_data[%0d]", e.id), bus.read_data, e.exp_data);
      check(irq == e.exp_irq, $sformatf("irq[%0d]", e.id), irq, e.exp_irq);
    end
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    logic [8:0]  a;
    logic [15:0] wd;
    logic [1:0]  cmd;
    int          r;
    exp_t        e;

    reset_n = 1'b0;
    m_rst   = 1'b1;
    model_reset();
    bus.mem_cmd = CMD_NONE; bus.mem_addr = 9'h0; bus.write_data = 16'h0;
    @(posedge clk); #1;

    // Reset and read
    for (int i = 0; i < 8; i++) rd_chk(3'(i), 16'h0000, 1'b0);
    issue(CMD_MREAD, 9'h188, 16'h0, 1'b1, 16'h0, 1'b0);
    reset_n = 1'b1;
    m_rst   = 1'b0;
    idle();

    // Auto-reload: COUNT 0,1,2,3,0 with irq rising after the 4th tick
    wr(3'd4, 16'd0);
    wr(3'd2, 16'd3);
    wr(3'd1, 16'd0);
    wr(3'd0, 16'd3);
    rd_chk(3'd1, 16'd0, 1'b0);
    rd_chk(3'd1, 16'd1, 1'b0);
    rd_chk(3'd1, 16'd2, 1'b0);
    rd_chk(3'd1, 16'd3, 1'b0);
    rd_chk(3'd1, 16'd0, 1'b1);
    wr(3'd3, 16'h0001);
    rd_chk(3'd3, 16'h0000, 1'b0);

    // Prescale 2 with one-shot
    stop_and_clear();
    wr(3'd1, 16'd0);
    wr(3'd4, 16'd2);
    wr(3'd2, 16'd1);
    wr(3'd0, 16'd5);
    for (int k = 0; k < 9; k++) rd_chk(3'd1, 16'(k / 3), logic'(k >= 6));
    rd_chk(3'd0, 16'h0004, 1'b1);
    rd_chk(3'd1, 16'd2, 1'b1);

    // Overflow
    stop_and_clear();
    wr(3'd4, 16'd0);
    wr(3'd2, 16'h0010);
    wr(3'd1, 16'hFFFE);
    wr(3'd0, 16'd1);
    rd_chk(3'd1, 16'hFFFE, 1'b0);
    rd_chk(3'd1, 16'hFFFF, 1'b0);
    rd_chk(3'd1, 16'h0000, 1'b0);
    rd_chk(3'd3, 16'h0002, 1'b0);

    // COUNT write beats a matching tick
    stop_and_clear();
    wr(3'd2, 16'd5);
    wr(3'd1, 16'd5);
    wr(3'd0, 16'd1);
    wr(3'd1, 16'h0050);
    rd_chk(3'd1, 16'h0050, 1'b0);
    rd_chk(3'd3, 16'h0000, 1'b0);

    // Hardware MATCH set beats same-cycle W1C
    stop_and_clear();
    wr(3'd2, 16'd5);
    wr(3'd1, 16'd5);
    wr(3'd0, 16'd1);
    wr(3'd3, 16'h0001);
    rd_chk(3'd3, 16'h0001, 1'b1);

    // Randomized traffic against the model
    stop_and_clear();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? CMD_MWRITE : (r < 8) ? CMD_MREAD : CMD_NONE;
      a = ($urandom_range(0, 9) == 0) ? 9'($urandom) : {BASE[8:3], 3'($urandom_range(0, 7))};
      case (a[2:0])
        3'd0: wd = 16'($urandom_range(0, 7)) | 16'(($urandom_range(0, 3) != 0) ? 1 : 0);
        3'd1: wd = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                : 16'($urandom_range(0, 15));
        3'd2: wd = 16'($urandom_range(0, 15));
        3'd3: wd = 16'($urandom_range(0, 3));
        3'd4: wd = 16'($urandom_range(0, 3));
        default: wd = 16'($urandom);
      endcase
      // Keep writes sparse so the counter gets time to run.
      if (cmd == CMD_MWRITE && $urandom_range(0, 2) != 0) cmd = CMD_NONE;
      issue(cmd, a, wd, 1'b0, 16'h0, 1'b0);
    end

    // Async reset between edges while running with MATCH set
    stop_and_clear();
    wr(3'd4, 16'd0);
    wr(3'd2, 16'd2);
    wr(3'd1, 16'd0);
    wr(3'd0, 16'd3);
    for (int k = 0; k < 5; k++) idle();
    bus.mem_cmd = CMD_MREAD; bus.mem_addr = {BASE[8:3], 3'd1}; bus.write_data = 16'h0;
    #1;
    check(irq == 1'b1, "pre_reset_irq", irq, 1);
    check(bus.read_data == model_read(3'd1), "pre_reset_count", bus.read_data, model_read(3'd1));
    reset_n = 1'b0;
    m_rst   = 1'b1;
    model_reset();
    #1;
    check(bus.read_data == 16'h0000, "async_count", bus.read_data, 0);
    check(irq == 1'b0, "async_irq", irq, 0);
    check(bus.rd_sel == 1'b1, "async_rd_sel", bus.rd_sel, 1);
    bus.mem_addr = {BASE[8:3], 3'd0};
    #1;
    check(bus.read_data == 16'h0000, "async_ctrl", bus.read_data, 0);
    e.exp_sel = 1'b1; e.exp_data = 16'h0000; e.exp_irq = 1'b0; e.id = cyc_id++;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_rst   = 1'b0;
    rd_chk(3'd1, 16'h0000, 1'b0);
    idle();

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
